// File: rtl/instr_queue_if.sv
// Fetch-to-decode handshake bundle: fetch/flush inputs, head-of-queue outputs and occupancy.
// The master modport drives the producer and consumer side; the slave modport is the queue.
interface instr_queue_if #(
  parameter int INSTR_WIDTH = 120,
  parameter int LEN_WIDTH   = 4,
  parameter int DEPTH       = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   i_flush;
  logic                   i_instr_valid;
  logic [INSTR_WIDTH-1:0] i_instr;
  logic [LEN_WIDTH-1:0]   i_instr_len;
  logic                   o_ready;
  logic                   o_res_valid;
  logic [INSTR_WIDTH-1:0] o_instr;
  logic [LEN_WIDTH-1:0]   o_instr_len;
  logic                   i_next_ready;
  logic [CW-1:0]          o_count;

  modport slave (
    input  i_flush, i_instr_valid, i_instr, i_instr_len, i_next_ready,
    output o_ready, o_res_valid, o_instr, o_instr_len, o_count
  );

  modport master (
    output i_flush, i_instr_valid, i_instr, i_instr_len, i_next_ready,
    input  o_ready, o_res_valid, o_instr, o_instr_len, o_count
  );
endinterface

// File: rtl/instr_queue.sv
// Instruction FIFO between fetch and decode. Latency 1 cycle, or 0 when INSTR_QUEUE_BYPASS_EN is defined and the queue is empty.
// o_ready depends only on occupancy, so there is no path from consumer ready back to fetch.
module instr_queue #(
  parameter int INSTR_WIDTH = 120,
  parameter int LEN_WIDTH   = 4,
  parameter int DEPTH       = 4
) (
  input logic          clk,
  input logic          reset,
  instr_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [LEN_WIDTH-1:0]   len_mem_q   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty, full, push, pop, bypass;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

`ifdef INSTR_QUEUE_BYPASS_EN
  assign bypass = empty && q.i_instr_valid && (q.i_instr_len != '0) &&
                  q.i_next_ready && !q.i_flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction goes straight to the consumer and is never stored.
  assign push = q.i_instr_valid && !full && (q.i_instr_len != '0) && !q.i_flush && !bypass;
  assign pop  = !empty && q.i_next_ready && !q.i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= q.i_instr;
      len_mem_q[wr_ptr_q]   <= q.i_instr_len;
    end
  end

  always_comb begin
    q.o_ready     = !full;
    q.o_count     = count_q;
    q.o_res_valid = !empty || bypass;
    q.o_instr     = '0;
    q.o_instr_len = '0;
    if (bypass) begin
      q.o_instr     = q.i_instr;
      q.o_instr_len = q.i_instr_len;
    end else if (!empty) begin
      q.o_instr     = instr_mem_q[rd_ptr_q];
      q.o_instr_len = len_mem_q[rd_ptr_q];
    end
  end
endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios followed by random traffic against a queue-based model.
module tb_instr_queue;
  localparam int IW = 120;
  localparam int LW = 4;
  localparam int DEPTH = 4;
`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [LW-1:0] len;
    logic [IW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  ent_t mq[$];

  instr_queue_if #(.INSTR_WIDTH(IW), .LEN_WIDTH(LW), .DEPTH(DEPTH)) bus ();

  instr_queue #(.INSTR_WIDTH(IW), .LEN_WIDTH(LW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 128'(bus.o_ready), 128'(1));
    check({tag, "_valid"}, 128'(bus.o_res_valid), 128'(0));
    check({tag, "_count"}, 128'(bus.o_count), 128'(0));
    check({tag, "_len"}, 128'(bus.o_instr_len), 128'(0));
    check({tag, "_instr"}, 128'(bus.o_instr), 128'(0));
  endtask

  // One cycle: drive inputs after the falling edge, compare against the model, then advance the model.
  task automatic cyc(input logic vld, input logic [IW-1:0] d, input logic [LW-1:0] len,
                     input logic nr, input logic fl);
    int sz;
    bit byp, rdy;
    ent_t head;
    @(negedge clk);
    bus.i_instr_valid = vld;
    bus.i_instr       = d;
    bus.i_instr_len   = len;
    bus.i_next_ready  = nr;
    bus.i_flush       = fl;
    #1;
    sz   = mq.size();
    rdy  = (sz != DEPTH);
    byp  = BYP && sz == 0 && vld && len != 0 && nr && !fl;
    head = '0;
    if (byp) head = '{len: len, d: d};
    else if (sz != 0) head = mq[0];
    check("ready", 128'(bus.o_ready), 128'(rdy));
    check("valid", 128'(bus.o_res_valid), 128'(sz != 0 || byp));
    check("count", 128'(bus.o_count), 128'(sz));
    check("len", 128'(bus.o_instr_len), 128'(head.len));
    check("instr", 128'(bus.o_instr), 128'(head.d));
    if (fl) mq.delete();
    else if (!byp) begin
      if (sz != 0 && nr) void'(mq.pop_front());
      if (vld && rdy && len != 0) mq.push_back('{len: len, d: d});
    end
  endtask

  function automatic logic [IW-1:0] rnd_instr();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[IW-1:0];
  endfunction

  initial begin
    bus.i_flush = 1'b0;
    bus.i_instr_valid = 1'b0;
    bus.i_instr = '0;
    bus.i_instr_len = '0;
    bus.i_next_ready = 1'b0;
    #1;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b0;
    cyc(0, '0, 0, 0, 0);

    // Single push then pop
    cyc(1, {15{8'hAA}}, 3, 0, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 0, 0);

    // Fill, rejected fifth offer, drain in order
    for (int i = 1; i <= 4; i++) cyc(1, rnd_instr(), LW'(i), 0, 0);
    cyc(1, rnd_instr(), 5, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, '0, 0, 1, 0);

    // Steady state at two entries across pointer wrap
    cyc(1, rnd_instr(), 7, 0, 0);
    cyc(1, rnd_instr(), 8, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, rnd_instr(), LW'(i + 1), 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0);

    // Flush with a concurrent offer
    for (int i = 0; i < 3; i++) cyc(1, rnd_instr(), LW'(i + 2), 0, 0);
    cyc(1, rnd_instr(), 9, 1, 1);
    cyc(0, '0, 0, 1, 0);

    // Zero-length bubble, then an offer into an empty queue with consumer ready
    cyc(1, rnd_instr(), 2, 0, 0);
    cyc(1, rnd_instr(), 0, 0, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(1, rnd_instr(), 5, 1, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 0, 0);

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) cyc(1, rnd_instr(), LW'(i + 1), 0, 0);
    @(negedge clk);
    bus.i_instr_valid = 1'b0;
    bus.i_next_ready = 1'b0;
    bus.i_instr_len = '0;
    #2;
    check("pre_rst_count", 128'(bus.o_count), 128'(3));
    reset = 1'b1;
    #1;
    check_idle("async_rst");
    mq.delete();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [LW-1:0] len;
      len = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom_range(1, 15));
      cyc(LW'($urandom_range(0, 9)) < 7, rnd_instr(), len,
          ($urandom_range(0, 9) < ((i / 200) % 2 == 0 ? 3 : 8)),
          ($urandom_range(0, 39) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
